// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one Wishbone B4 pipelined slave port
// between NUM_MASTERS masters (e.g. a JTAG-to-Wishbone host and a soft CPU).
//
// The grant is held for the whole bus cycle of the winning master. Accepted but
// not yet acknowledged requests are counted so that acks are only forwarded to
// the owning master while it still expects them; stray or late acks are dropped.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i  per-master Wishbone control (one bit per master)
//   m_adr_i, m_dat_i      packed per-master address / write data (master i = slice i)
//   m_dat_o               read data, broadcast to all masters
//   m_ack_o, m_stall_o    per-master ack / stall
//   m_err_o               per-master timeout error pulse
//   s_*                   single Wishbone pipelined slave port
//   grant_o               one-hot current grant (status)
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the watchdog that aborts a
// granted cycle after TIMEOUT_CYCLES cycles without an ack while requests are
// outstanding. Without the macro m_err_o is tied low.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_stall_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_stall_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_rr_arbiter: parameter out of range");
  end

  logic [0:0]             state_q, state_d;
  logic [IdxW-1:0]        gidx_q, gidx_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CntW-1:0]        out_q, out_d;

  logic                   busy;
  logic                   full;
  logic                   cyc_g, stb_g, we_g;
  logic                   accept;
  logic                   ack_fwd;
  logic                   timeout;
  logic [NUM_MASTERS-1:0] req;
  logic                   pick_valid;
  logic [IdxW-1:0]        pick_idx;

  assign busy  = (state_q == StBusy);
  assign full  = (out_q == CntW'(MAX_OUTSTANDING));
  assign cyc_g = m_cyc_i[gidx_q];
  assign stb_g = m_stb_i[gidx_q];
  assign we_g  = m_we_i[gidx_q];

  // Slave side: only the granted master's signals ever reach the slave.
  assign s_cyc_o = busy & cyc_g & ~timeout;
  assign s_stb_o = s_cyc_o & stb_g & ~full;
  assign s_we_o  = busy & we_g;
  assign s_adr_o = m_adr_i[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_dat_o = m_dat_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];

  assign accept  = s_stb_o & ~s_stall_i;
  // Acks with nothing outstanding, or after the owner dropped cyc, are stray.
  assign ack_fwd = busy & cyc_g & s_ack_i & (out_q != '0);

  assign m_dat_o = s_dat_i;
  assign m_ack_o = ack_fwd ? grant_q : '0;
  assign grant_o = grant_q;

  always_comb begin
    m_stall_o = '1;
    if (busy) begin
      m_stall_o[gidx_q] = s_stall_i | full;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0]         wd_q, wd_d;
  // A master hit by a timeout stays out of arbitration until it drops cyc once.
  logic [NUM_MASTERS-1:0] blocked_q, blocked_d;

  assign timeout = busy & cyc_g & (out_q != '0) & ~s_ack_i &
                   (wd_q == WdW'(TIMEOUT_CYCLES - 1));
  assign m_err_o = timeout ? grant_q : '0;
  assign req     = m_cyc_i & ~blocked_q;

  always_comb begin
    wd_d      = wd_q;
    blocked_d = blocked_q & m_cyc_i;
    if (!busy || s_ack_i) begin
      wd_d = '0;
    end else if (out_q != '0) begin
      wd_d = wd_q + 1'b1;
    end
    if (timeout) begin
      blocked_d[gidx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q      <= '0;
      blocked_q <= '0;
    end else begin
      wd_q      <= wd_d;
      blocked_q <= blocked_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign m_err_o = '0;
  assign req     = m_cyc_i;
`endif

  // Round-robin search starting just after the last granted master.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = (32'(last_q) + k) % NUM_MASTERS;
      if (!pick_valid && req[IdxW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
    out_d   = out_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          gidx_d  = pick_idx;
          grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
          out_d   = '0;
        end
      end
      default: begin
        if (!cyc_g || timeout) begin
          // Release or abort: anything still outstanding is forgotten.
          state_d = StIdle;
          last_d  = gidx_q;
          grant_d = '0;
          out_d   = '0;
        end else if (accept && !ack_fwd) begin
          out_d = out_q + 1'b1;
        end else if (!accept && ack_fwd) begin
          out_d = out_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gidx_q  <= '0;
      last_q  <= IdxW'(NUM_MASTERS - 1);
      grant_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone B4 pipelined slave port between NUM_MASTERS masters.
- Masters are, for example, the JTAG-to-Wishbone host and a soft CPU.
- Grant is locked for the whole bus cycle (cyc high). Outstanding requests are tracked so that acks route to the correct master.
- Sits between the master-side bridges and the slave interconnect/decoder.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 16, Wishbone address width.
- DATA_WIDTH, 16, Wishbone data width.
- MAX_OUTSTANDING, 4, maximum accepted-but-unacked requests per grant (1..15).
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master we.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i occupies slice i.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_stall_o  out  NUM_MASTERS  per-master stall.
- m_err_o  out  NUM_MASTERS  per-master timeout error.
- s_cyc_o  out  1  slave cyc.
- s_stb_o  out  1  slave stb.
- s_we_o  out  1  slave we.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- s_stall_i  in  1  slave stall.
- grant_o  out  NUM_MASTERS  one-hot current grant (debug/status).

Behaviour:
- Reset values:
  - State = IDLE; grant_o = 0; last_grant = NUM_MASTERS-1, so master 0 wins first; outstanding = 0.
  - s_cyc_o/s_stb_o/s_we_o = 0; m_ack_o = 0; m_err_o = 0; m_stall_o = all 1.
  - Reset mid-transaction aborts the cycle immediately. No ack is issued.
- State IDLE:
  - All m_stall_o = 1; s_cyc_o = 0.
  - If any m_cyc_i is high, pick the first requester searching from last_grant+1 upward (with wrap).
  - Register it into grant_o and go to BUSY.
  - Grant latency: 1 cycle from m_cyc_i to first possible s_stb_o.
- State BUSY, granted master g:
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & ~full; s_we_o, s_adr_o, s_dat_o muxed from slice g.
  - m_stall_o[g] = s_stall_i | full. All other m_stall_o = 1.
  - full = (outstanding == MAX_OUTSTANDING).
- Accepted request = s_stb_o & ~s_stall_i → outstanding+1.
- Routed ack:
  - s_ack_i with outstanding>0 → m_ack_o[g] = 1 (combinational) and outstanding−1.
  - Accept and ack in the same cycle → count unchanged.
  - s_ack_i with outstanding==0 is spurious: dropped, never forwarded.
- m_dat_o = s_dat_i always (masters qualify with ack).
- Release:
  - When m_cyc_i[g] falls, go to IDLE next cycle; last_grant = g; grant_o = 0.
  - Falling cyc with outstanding>0 is an abort: counter cleared, late acks dropped.
- A master requesting continuously is held for its own whole cycle. Other requesters wait, with no preemption.
- Back-to-back: a released master re-requesting competes after the other masters. There is a 1-cycle IDLE bubble between grants.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - Watchdog counter counts cycles in BUSY while outstanding>0 and s_ack_i==0. It resets on any ack or on entering BUSY.
  - On reaching TIMEOUT_CYCLES: pulse m_err_o[g] for 1 cycle, force s_cyc_o = 0 that cycle, clear outstanding, go to IDLE, set last_grant = g.
  - The granted master must then drop cyc. It is not re-granted until its cyc has been low for at least 1 cycle.
- Not defined: no watchdog logic; m_err_o tied to 0.

Test Plan:
- Master0 only: write adr=0x0010 dat=0xBEEF, slave stall=0, ack 2 cycles later → s_stb_o 1 cycle after m_cyc_i; m_ack_o=01; grant_o returns to 00 after cyc falls.
- m0 and m1 assert cyc in the same cycle out of reset → m0 granted first with m1 stalled throughout; then m1 granted. The next simultaneous request goes to m0 again, because last_grant=1.
- m0 issues 6 pipelined reads with MAX_OUTSTANDING=4 and the slave withholding ack → exactly 4 accepted, m_stall_o[0]=1. The first ack re-opens acceptance; 6 acks routed and m_dat_o matches each ack.
- Spurious s_ack_i in IDLE, and m0 dropping cyc with 2 outstanding followed by 2 late acks → no m_ack_o asserted; m1 granted cleanly.
- Slave asserts s_stall_i=1 for 5 cycles → request held stable on s_adr_o/s_dat_o; accepted on the first cycle s_stall_i=0; outstanding=1.
- With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m0 read never acked → m_err_o[0] pulses at cycle 16 after accept; state IDLE; a pending m1 is granted next.
